serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor, the sequential successor to the team's combinational half/full adders.
- Processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake.
- Serves the area-constrained datapaths and the teaching examples that contrast serial and parallel addition.

---
 rtl/serial_addsub.sv | 98 +++++++++
 tb/tb_serial_addsub.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop, LSB first,
// with a start/busy/done handshake. Subtraction is computed as a + ~b + 1.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             carry_next;
    logic             last_bit;

    always_comb begin
        bit_s      = sh_a[0] ^ sh_b[0] ^ carry;
        carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        // NOTE: acc_next gets a full default before the MSB override, so no latch is inferred.
        acc_next            = acc >> 1;
        acc_next[WIDTH-1]   = bit_s;
        last_bit            = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= carry_next;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    // MSB stage: carry holds the carry into the MSB, carry_next the carry out.
                    if (last_bit) begin
                        sum   <= acc_next;
                        cout  <= carry_next;
                        ovf   <= carry ^ carry_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub at WIDTH=8, 4 and 1; expected results come from
// a signed/unsigned arithmetic reference model and are checked by per-instance monitors.
module tb_serial_addsub;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic       start8 = 0, sub8 = 0, busy8, done8, cout8, ovf8;
    logic [7:0] a8 = 0, b8 = 0, sum8;
    logic       start4 = 0, sub4 = 0, busy4, done4, cout4, ovf4;
    logic [3:0] a4 = 0, b4 = 0, sum4;
    logic       start1 = 0, sub1 = 0, busy1, done1, cout1, ovf1;
    logic [0:0] a1 = 0, b1 = 0, sum1;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );
    serial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Reference: plain integer a+b / a-b, unsigned for carry, signed range test for overflow.
    function automatic exp_t ref_model(input int w, input longint a, input longint b, input bit s);
        longint m, half, sa, sb, r, sr;
        exp_t   e;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        r    = s ? a - b : a + b;
        sr   = s ? sa - sb : sa + sb;
        e.sum  = 64'(((r % m) + m) % m);
        e.cout = s ? (a >= b) : (r >= m);
        e.ovf  = (sr < -half) || (sr >= half);
        return e;
    endfunction

    // Monitors: pop on done; otherwise outputs must hold the last completed result.
    logic [9:0] snap8 = '0;
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst_n) begin
            snap8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                check("w8 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check("w8 sum", 64'(sum8), e.sum);
                check("w8 cout", 64'(cout8), 64'(e.cout));
                check("w8 ovf", 64'(ovf8), 64'(e.ovf));
            end
            snap8 = {sum8, cout8, ovf8};
        end else begin
            check("w8 outputs hold", 64'({sum8, cout8, ovf8}), 64'(snap8));
        end
    end

    logic [5:0] snap4 = '0;
    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst_n) begin
            snap4 = '0;
        end else if (done4) begin
            if (q4.size() == 0) begin
                check("w4 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q4.pop_front();
                check("w4 sum", 64'(sum4), e.sum);
                check("w4 cout", 64'(cout4), 64'(e.cout));
                check("w4 ovf", 64'(ovf4), 64'(e.ovf));
            end
            snap4 = {sum4, cout4, ovf4};
        end else begin
            check("w4 outputs hold", 64'({sum4, cout4, ovf4}), 64'(snap4));
        end
    end

    logic [2:0] snap1 = '0;
    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst_n) begin
            snap1 = '0;
        end else if (done1) begin
            if (q1.size() == 0) begin
                check("w1 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check("w1 sum", 64'(sum1), e.sum);
                check("w1 cout", 64'(cout1), 64'(e.cout));
                check("w1 ovf", 64'(ovf1), 64'(e.ovf));
            end
            snap1 = {sum1, cout1, ovf1};
        end else begin
            check("w1 outputs hold", 64'({sum1, cout1, ovf1}), 64'(snap1));
        end
    end

    // Drivers: one start pulse, then measure cycles to done and busy length.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
        int n, nb;
        @(negedge clk);
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        nb = busy8 ? 1 : 0;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
            if (busy8) nb++;
        end
        check("w8 latency", 64'(n), 64'd9);
        check("w8 busy cycles", 64'(nb), 64'd8);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input exp_t e);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w4 latency", 64'(n), 64'd5);
    endtask

    task automatic run1(input logic a, input logic b, input logic s, input exp_t e);
        int n;
        @(negedge clk);
        a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w1 latency", 64'(n), 64'd2);
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic       rs;

        repeat (3) @(negedge clk);
        check("reset outputs", 64'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
        rst_n = 1'b1;

        run8(8'h5A, 8'h3C, 1'b0, mk(64'h96, 1'b0, 1'b1));
        run8(8'hFF, 8'h01, 1'b0, mk(64'h00, 1'b1, 1'b0));
        run8(8'h10, 8'h20, 1'b1, mk(64'hF0, 1'b0, 1'b0));
        run8(8'h80, 8'h01, 1'b1, mk(64'h7F, 1'b1, 1'b1));
        run8(8'h7F, 8'h7F, 1'b1, mk(64'h00, 1'b1, 1'b0));

        // start and operand changes during RUN must be ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back(mk(64'h46, 1'b0, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n);
        check("ignored start: done seen", 64'(n < 50), 64'd1);
        repeat (12) @(negedge clk);
        check("ignored start: queue drained", 64'(q8.size()), 64'd0);

        // back-to-back with start held high
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back(mk(64'h02, 1'b0, 1'b0));
        q8.push_back(mk(64'h04, 1'b0, 1'b0));
        @(negedge clk);
        a8 = 8'h02; b8 = 8'h02;
        wait_done8(n);
        @(negedge clk);
        check("b2b busy/done after done", 64'({busy8, done8}), 64'b10);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b period", 64'(n), 64'd9);
        repeat (3) @(negedge clk);

        // asynchronous reset in RUN cycle 4
        a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset outputs", 64'({busy8, done8, sum8, cout8, ovf8}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no done after abort", 64'({busy8, done8}), 64'd0);
        run8(8'h03, 8'h04, 1'b0, mk(64'h07, 1'b0, 1'b0));

        repeat (200) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run8(ra, rb, rs, ref_model(8, longint'(ra), longint'(rb), rs));
        end

        fork
            begin
                run1(1'b1, 1'b1, 1'b0, mk(64'h0, 1'b1, 1'b1));
                run1(1'b0, 1'b1, 1'b1, mk(64'h1, 1'b0, 1'b1));
                for (int x = 0; x < 2; x++)
                    for (int y = 0; y < 2; y++)
                        for (int s = 0; s < 2; s++)
                            run1(1'(x), 1'(y), 1'(s), ref_model(1, longint'(x), longint'(y), s[0]));
            end
            begin
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++)
                        for (int s = 0; s < 2; s++)
                            run4(4'(x), 4'(y), 1'(s), ref_model(4, longint'(x), longint'(y), s[0]));
            end
        join

        repeat (5) @(negedge clk);
        check("all results seen", 64'(q8.size() + q4.size() + q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
